// File: rtl/cov_stream_accum.sv
// Streaming Hermitian covariance estimator: accumulates the upper triangle of sum(x*x^H) over
// 2^L snapshots, then normalises, saturates and streams the N(N+1)/2 elements out.
module cov_stream_accum #(
  parameter int unsigned N                = 4,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned MAX_LOG2_SAMPLES = 12,
  parameter int unsigned ACC_WIDTH        = 48,
  parameter int unsigned OUT_WIDTH        = 24,
  localparam int unsigned LW              = $clog2(MAX_LOG2_SAMPLES + 1),
  localparam int unsigned IW              = $clog2(N)
) (
  input  logic                         iclk,
  input  logic                         irst_n,
  input  logic                         istart,
  input  logic                         iabort,
  input  logic [LW-1:0]                ilog2_samples,
  input  logic                         idata_valid,
  input  logic [N*DATA_WIDTH-1:0]      idata_i,
  input  logic [N*DATA_WIDTH-1:0]      idata_q,
  output logic                         obusy,
  output logic                         ocalu_done,
  output logic                         oovf,
  output logic                         oout_valid,
  input  logic                         iout_ready,
  output logic [IW-1:0]                oout_row,
  output logic [IW-1:0]                oout_col,
  output logic signed [OUT_WIDTH-1:0]  oout_re,
  output logic signed [OUT_WIDTH-1:0]  oout_im,
  output logic                         oout_last
);

  localparam int unsigned P  = N * (N + 1) / 2;
  localparam int unsigned EW = $clog2(P);
  localparam int unsigned CW = MAX_LOG2_SAMPLES + 1;
  localparam int unsigned PW = 2 * DATA_WIDTH + 2;

  if (ACC_WIDTH < 2 * DATA_WIDTH + 2 + MAX_LOG2_SAMPLES) begin : g_acc_width_check
    $error("ACC_WIDTH too small for worst-case accumulation");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

  state_e                      state_q;
  logic [LW-1:0]               l_q, l_in;
  logic [CW-1:0]               cnt_q, frame_len;
  logic                        accept, last_in, hs;
  logic                        in_valid_q, in_last_q, prod_valid_q, prod_last_q;
  logic [N*DATA_WIDTH-1:0]     in_i_q, in_q_q;
  logic signed [PW-1:0]        pre_re [P];
  logic signed [PW-1:0]        pre_im [P];
  logic signed [PW-1:0]        prod_re_q [P];
  logic signed [PW-1:0]        prod_im_q [P];
  logic signed [ACC_WIDTH-1:0] acc_re_q [P];
  logic signed [ACC_WIDTH-1:0] acc_im_q [P];
  logic [EW-1:0]               el_q;
  logic [IW-1:0]               row_q, col_q;
  logic                        ovf_q, done_q;
  logic [OUT_WIDTH:0]          norm_re, norm_im;

  assign l_in = (int'(ilog2_samples) > int'(MAX_LOG2_SAMPLES)) ? LW'(MAX_LOG2_SAMPLES)
                                                                : ilog2_samples;
  assign frame_len = CW'(1) << l_q;
  // Snapshots beyond 2^L are ignored while the pipeline drains into the accumulators.
  assign accept    = (state_q == StAcc) && idata_valid && (cnt_q != frame_len);
  assign last_in   = accept && (cnt_q == frame_len - CW'(1));
  assign hs        = oout_valid && iout_ready;

  // Products for every upper-triangle pair, packed row-major.
  always_comb begin
    int unsigned k;
    logic signed [DATA_WIDTH-1:0] ii, qi, ij, qj;
    k = 0;
    for (int p = 0; p < P; p++) begin
      pre_re[p] = '0;
      pre_im[p] = '0;
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ii = in_i_q[i*DATA_WIDTH +: DATA_WIDTH];
        qi = in_q_q[i*DATA_WIDTH +: DATA_WIDTH];
        ij = in_i_q[j*DATA_WIDTH +: DATA_WIDTH];
        qj = in_q_q[j*DATA_WIDTH +: DATA_WIDTH];
        if (j >= i) begin
          pre_re[k] = PW'(ii) * PW'(ij) + PW'(qi) * PW'(qj);
          if (i != j) pre_im[k] = PW'(qi) * PW'(ij) - PW'(ii) * PW'(qj);
          k++;
        end
      end
    end
  end

  // Returns {saturated, value}: rounded arithmetic shift by L, clipped to OUT_WIDTH.
  function automatic logic [OUT_WIDTH:0] norm(input logic signed [ACC_WIDTH-1:0] a,
                                              input logic [LW-1:0] l);
    logic signed [ACC_WIDTH:0] rnd, s, hi, lo;
    rnd = (l == '0) ? '0 : ((ACC_WIDTH+1)'(1) << (l - LW'(1)));
    s   = ((ACC_WIDTH+1)'(a) + rnd) >>> l;
    hi  = {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    lo  = ~hi;
    if (s > hi)      return {1'b1, hi[OUT_WIDTH-1:0]};
    else if (s < lo) return {1'b1, lo[OUT_WIDTH-1:0]};
    else             return {1'b0, s[OUT_WIDTH-1:0]};
  endfunction

  assign norm_re = norm(acc_re_q[el_q], l_q);
  assign norm_im = norm(acc_im_q[el_q], l_q);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q      <= StIdle;
      l_q          <= '0;
      cnt_q        <= '0;
      in_valid_q   <= 1'b0;
      in_last_q    <= 1'b0;
      in_i_q       <= '0;
      in_q_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      el_q         <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      for (int k = 0; k < P; k++) begin
        prod_re_q[k] <= '0;
        prod_im_q[k] <= '0;
        acc_re_q[k]  <= '0;
        acc_im_q[k]  <= '0;
      end
    end else begin
      done_q       <= 1'b0;
      in_valid_q   <= accept;
      in_last_q    <= last_in;
      prod_valid_q <= in_valid_q;
      prod_last_q  <= in_valid_q && in_last_q;
      if (accept) begin
        in_i_q <= idata_i;
        in_q_q <= idata_q;
        cnt_q  <= cnt_q + CW'(1);
      end
      for (int k = 0; k < P; k++) begin
        if (in_valid_q) begin
          prod_re_q[k] <= pre_re[k];
          prod_im_q[k] <= pre_im[k];
        end
        if (prod_valid_q) begin
          acc_re_q[k] <= acc_re_q[k] + ACC_WIDTH'(prod_re_q[k]);
          acc_im_q[k] <= acc_im_q[k] + ACC_WIDTH'(prod_im_q[k]);
        end
      end
      if (hs && (norm_re[OUT_WIDTH] || norm_im[OUT_WIDTH])) ovf_q <= 1'b1;

      if (iabort) begin
        state_q      <= StIdle;
        cnt_q        <= '0;
        in_valid_q   <= 1'b0;
        in_last_q    <= 1'b0;
        prod_valid_q <= 1'b0;
        prod_last_q  <= 1'b0;
        el_q         <= '0;
        row_q        <= '0;
        col_q        <= '0;
        ovf_q        <= ovf_q;
        for (int k = 0; k < P; k++) begin
          acc_re_q[k] <= '0;
          acc_im_q[k] <= '0;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (istart) begin
              state_q <= StAcc;
              l_q     <= l_in;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              for (int k = 0; k < P; k++) begin
                acc_re_q[k] <= '0;
                acc_im_q[k] <= '0;
              end
            end
          end
          StAcc: begin
            if (prod_last_q) state_q <= StDrain;
          end
          StDrain: begin
            if (hs) begin
              if (oout_last) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
                el_q    <= '0;
                row_q   <= '0;
                col_q   <= '0;
              end else begin
                el_q <= el_q + EW'(1);
                if (col_q == IW'(N - 1)) begin
                  row_q <= row_q + IW'(1);
                  col_q <= row_q + IW'(1);
                end else begin
                  col_q <= col_q + IW'(1);
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign obusy      = (state_q != StIdle);
  assign ocalu_done = done_q;
  assign oovf       = ovf_q;
  assign oout_valid = (state_q == StDrain);
  assign oout_row   = row_q;
  assign oout_col   = col_q;
  assign oout_last  = oout_valid && (row_q == IW'(N - 1)) && (col_q == IW'(N - 1));
  assign oout_re    = oout_valid ? norm_re[OUT_WIDTH-1:0] : '0;
  assign oout_im    = oout_valid ? norm_im[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_cov_stream_accum.sv
// Bench for cov_stream_accum: table of frames checked through an expected-element queue,
// plus abort, async reset and start-during-drain sequences.
module tb_cov_stream_accum;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int ML = 12;
  localparam int OW = 24;
  localparam int LW = 4;
  localparam int IW = 2;

  logic                 iclk = 1'b0;
  logic                 irst_n, istart, iabort, idata_valid, iout_ready;
  logic [LW-1:0]        ilog2_samples;
  logic [N*DW-1:0]      idata_i, idata_q;
  logic                 obusy, ocalu_done, oovf, oout_valid, oout_last;
  logic [IW-1:0]        oout_row, oout_col;
  logic signed [OW-1:0] oout_re, oout_im;

  cov_stream_accum dut (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .istart        (istart),
    .iabort        (iabort),
    .ilog2_samples (ilog2_samples),
    .idata_valid   (idata_valid),
    .idata_i       (idata_i),
    .idata_q       (idata_q),
    .obusy         (obusy),
    .ocalu_done    (ocalu_done),
    .oovf          (oovf),
    .oout_valid    (oout_valid),
    .iout_ready    (iout_ready),
    .oout_row      (oout_row),
    .oout_col      (oout_col),
    .oout_re       (oout_re),
    .oout_im       (oout_im),
    .oout_last     (oout_last)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int     l;
    int     ai[N];
    int     aq[N];
    int     bi[N];
    int     bq[N];
    bit     gap;
    bit     rnd_rdy;
    longint e00;
    longint e01re;
    longint e01im;
    bit     eovf;
  } vec_t;

  typedef struct {
    int     row;
    int     col;
    longint re;
    longint im;
    bit     last;
  } exp_t;

  vec_t tv[7];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint bnorm(input longint s, input int l, output bit sat);
    longint v, mx, mn;
    v = (l > 0) ? s + (longint'(1) << (l - 1)) : s;
    v = v >>> l;
    mx = (longint'(1) << (OW - 1)) - 1;
    mn = -(longint'(1) << (OW - 1));
    sat = 1'b0;
    if (v > mx) begin
      sat = 1'b1;
      v = mx;
    end else if (v < mn) begin
      sat = 1'b1;
      v = mn;
    end
    return v;
  endfunction

  task automatic drive_sample(input int ci[N], input int cq[N]);
    for (int k = 0; k < N; k++) begin
      idata_i[k*DW +: DW] = DW'(ci[k]);
      idata_q[k*DW +: DW] = DW'(cq[k]);
    end
  endtask

  task automatic drive_junk();
    for (int k = 0; k < N; k++) begin
      idata_i[k*DW +: DW] = DW'($urandom);
      idata_q[k*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, obusy, 0);
    check({tag, "_valid"}, oout_valid, 0);
    check({tag, "_done"}, ocalu_done, 0);
  endtask

  // abort_after >= 0 aborts the drain after that many handshakes.
  task automatic run_frame(input int k, input int abort_after, input bit start_in_drain);
    int     l_eff, ns, hs, cyc;
    longint sre[N][N];
    longint sim[N][N];
    int     ci[N];
    int     cq[N];
    bit     sat, any_sat, rdy, last_hs;
    longint d00, d01re, d01im;
    exp_t   e;
    l_eff = (tv[k].l > ML) ? ML : tv[k].l;
    ns = 1 << l_eff;
    any_sat = 1'b0;
    d00 = -99; d01re = -99; d01im = -99;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sre[i][j] = 0;
        sim[i][j] = 0;
      end

    @(negedge iclk);
    istart = 1'b1;
    ilog2_samples = LW'(tv[k].l);
    @(negedge iclk);
    istart = 1'b0;
    check("start_busy", obusy, 1);
    check("start_ovf_clear", oovf, 0);

    for (int s = 0; s < ns; s++) begin
      if (tv[k].gap) begin
        idata_valid = 1'b0;
        drive_junk();
        repeat (2) @(negedge iclk);
      end
      ci = (s % 2 == 0) ? tv[k].ai : tv[k].bi;
      cq = (s % 2 == 0) ? tv[k].aq : tv[k].bq;
      drive_sample(ci, cq);
      idata_valid = 1'b1;
      for (int i = 0; i < N; i++)
        for (int j = i; j < N; j++) begin
          sre[i][j] += longint'(ci[i]) * ci[j] + longint'(cq[i]) * cq[j];
          if (i != j) sim[i][j] += longint'(cq[i]) * ci[j] - longint'(ci[i]) * cq[j];
        end
      @(negedge iclk);
    end
    idata_valid = 1'b0;

    for (int i = 0; i < N; i++)
      for (int j = i; j < N; j++) begin
        e.row  = i;
        e.col  = j;
        e.re   = bnorm(sre[i][j], l_eff, sat);
        any_sat |= sat;
        e.im   = bnorm(sim[i][j], l_eff, sat);
        any_sat |= sat;
        e.last = (i == N - 1) && (j == N - 1);
        sbq.push_back(e);
      end

    check("lat_t1_valid", oout_valid, 0);
    @(negedge iclk);
    check("lat_t2_valid", oout_valid, 0);
    @(negedge iclk);
    check("lat_drain_valid", oout_valid, 1);

    hs = 0;
    cyc = 0;
    last_hs = 1'b0;
    while (1) begin
      if (cyc > 300) begin
        check("drain_timeout", 0, 1);
        break;
      end
      if (!oout_valid) begin
        check("drain_valid", oout_valid, 1);
        break;
      end
      if (sbq.size() == 0) begin
        check("sb_nonempty", 0, 1);
        break;
      end
      e = sbq[0];
      check("el_row", oout_row, e.row);
      check("el_col", oout_col, e.col);
      check("el_re", oout_re, e.re);
      check("el_im", oout_im, e.im);
      check("el_last", oout_last, e.last);
      if (hs == abort_after) begin
        iabort = 1'b1;
        iout_ready = 1'b1;
        @(negedge iclk);
        iabort = 1'b0;
        iout_ready = 1'b0;
        idata_valid = 1'b0;
        check_idle_outputs("abort_drain");
        repeat (3) begin
          @(negedge iclk);
          check("abort_drain_nodone", ocalu_done, 0);
        end
        sbq.delete();
        return;
      end
      istart = start_in_drain && (cyc == 0);
      ilog2_samples = LW'(3);
      idata_valid = 1'b1;
      drive_junk();
      rdy = tv[k].rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      iout_ready = rdy;
      if (rdy) begin
        void'(sbq.pop_front());
        hs++;
        last_hs = e.last;
        if (e.row == 0 && e.col == 0) d00 = oout_re;
        if (e.row == 0 && e.col == 1) begin
          d01re = oout_re;
          d01im = oout_im;
        end
      end
      @(negedge iclk);
      cyc++;
      if (rdy && last_hs) break;
    end
    istart = 1'b0;
    iout_ready = 1'b0;
    idata_valid = 1'b0;
    check("end_busy", obusy, 0);
    check("end_valid", oout_valid, 0);
    check("end_done_pulse", ocalu_done, 1);
    check("end_ovf_table", oovf, tv[k].eovf);
    check("end_ovf_model", oovf, any_sat);
    check("key_r00", d00, tv[k].e00);
    check("key_r01_re", d01re, tv[k].e01re);
    check("key_r01_im", d01im, tv[k].e01im);
    @(negedge iclk);
    check("done_one_cycle", ocalu_done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{l:2, ai:'{100, 100, 100, 100}, aq:'{0, 0, 0, 0},
              bi:'{100, 100, 100, 100}, bq:'{0, 0, 0, 0},
              gap:1'b0, rnd_rdy:1'b0, e00:10000, e01re:10000, e01im:0, eovf:1'b0};
    tv[1] = '{l:2, ai:'{0, 100, 0, 0}, aq:'{100, 0, 0, 0},
              bi:'{0, 100, 0, 0}, bq:'{100, 0, 0, 0},
              gap:1'b0, rnd_rdy:1'b0, e00:10000, e01re:0, e01im:10000, eovf:1'b0};
    tv[2] = '{l:0, ai:'{-32768, -32768, -32768, -32768}, aq:'{-32768, -32768, -32768, -32768},
              bi:'{-32768, -32768, -32768, -32768}, bq:'{-32768, -32768, -32768, -32768},
              gap:1'b0, rnd_rdy:1'b0, e00:8388607, e01re:8388607, e01im:0, eovf:1'b1};
    tv[3] = '{l:2, ai:'{100, 100, 100, 100}, aq:'{0, 0, 0, 0},
              bi:'{100, 100, 100, 100}, bq:'{0, 0, 0, 0},
              gap:1'b1, rnd_rdy:1'b1, e00:10000, e01re:10000, e01im:0, eovf:1'b0};
    tv[4] = '{l:1, ai:'{1, 1, 0, 0}, aq:'{0, 0, 0, 0}, bi:'{1, 2, 0, 0}, bq:'{0, 0, 0, 0},
              gap:1'b0, rnd_rdy:1'b1, e00:1, e01re:2, e01im:0, eovf:1'b0};
    tv[5] = '{l:1, ai:'{1, -1, 0, 0}, aq:'{0, 0, 0, 0}, bi:'{1, -2, 0, 0}, bq:'{0, 0, 0, 0},
              gap:1'b1, rnd_rdy:1'b0, e00:1, e01re:-1, e01im:0, eovf:1'b0};
    tv[6] = '{l:15, ai:'{1, 1, 1, 1}, aq:'{0, 0, 0, 0}, bi:'{1, 1, 1, 1}, bq:'{0, 0, 0, 0},
              gap:1'b0, rnd_rdy:1'b0, e00:1, e01re:1, e01im:0, eovf:1'b0};

    irst_n = 1'b0;
    istart = 1'b0;
    iabort = 1'b0;
    idata_valid = 1'b0;
    iout_ready = 1'b0;
    ilog2_samples = '0;
    idata_i = '0;
    idata_q = '0;
    @(negedge iclk);
    check("rst_busy", obusy, 0);
    check("rst_done", ocalu_done, 0);
    check("rst_ovf", oovf, 0);
    check("rst_valid", oout_valid, 0);
    check("rst_last", oout_last, 0);
    check("rst_row", oout_row, 0);
    check("rst_col", oout_col, 0);
    check("rst_re", oout_re, 0);
    check("rst_im", oout_im, 0);
    irst_n = 1'b1;

    run_frame(0, -1, 1'b0);
    run_frame(1, -1, 1'b0);
    run_frame(2, -1, 1'b0);
    repeat (3) begin
      @(negedge iclk);
      check("ovf_sticky", oovf, 1);
    end

    // Asynchronous reset in the middle of accumulation.
    istart = 1'b1;
    ilog2_samples = LW'(3);
    @(negedge iclk);
    istart = 1'b0;
    idata_valid = 1'b1;
    drive_junk();
    repeat (3) @(negedge iclk);
    #2 irst_n = 1'b0;
    #1;
    check("arst_busy", obusy, 0);
    check("arst_valid", oout_valid, 0);
    check("arst_ovf", oovf, 0);
    idata_valid = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;

    run_frame(3, -1, 1'b0);

    // Abort during accumulation with a product still in the pipeline.
    @(negedge iclk);
    istart = 1'b1;
    ilog2_samples = LW'(2);
    @(negedge iclk);
    istart = 1'b0;
    idata_valid = 1'b1;
    drive_junk();
    repeat (2) @(negedge iclk);
    iabort = 1'b1;
    istart = 1'b1;
    @(negedge iclk);
    iabort = 1'b0;
    istart = 1'b0;
    idata_valid = 1'b0;
    check_idle_outputs("abort_acc");
    repeat (4) begin
      @(negedge iclk);
      check("abort_acc_nodone", ocalu_done, 0);
      check("abort_acc_idle", obusy, 0);
    end

    run_frame(4, -1, 1'b0);
    run_frame(5, -1, 1'b0);
    run_frame(0, 3, 1'b0);
    run_frame(4, -1, 1'b1);
    run_frame(6, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
